// File: rtl/serial_rx_5b.sv
// -----------------------------------------------------------------------------
// serial_rx_5b
//   Strobe-paced serial receiver for 5-bit words. A frame is one start bit (0),
//   five data bits sent LSB first, then one stop bit (1). The line is sampled
//   once per bit period, on the cycles where the bit-period strobe en is high.
//   A good frame loads D and pulses valid. A frame whose stop bit is low is
//   dropped and pulses ferr instead. There is no timeout, so a stalled strobe
//   simply freezes the receiver where it is.
//
// Ports
//   clk    in   1  rising-edge system clock
//   reset  in   1  asynchronous, active-high reset
//   en     in   1  bit-period strobe; rx is only looked at when en=1
//   rx     in   1  serial line, idles high
//   D      out  5  last correctly framed word, D[0] = first data bit received
//   valid  out  1  one-cycle pulse, D has just been loaded with a new word
//   ferr   out  1  one-cycle pulse, stop bit was low and the frame was dropped
//   busy   out  1  high while a frame is in progress (DATA or STOP)
// -----------------------------------------------------------------------------
module serial_rx_5b (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       rx,
   output logic [4:0] D,
   output logic       valid,
   output logic       ferr,
   output logic       busy
);

   localparam int DATA_W = 5;
   localparam int CNT_W  = 3;

   // Counter value at which the final data bit is taken.
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      STOP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q,   cnt_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic [DATA_W-1:0]   d_q,     d_d;
   logic                valid_q, valid_d;
   logic                ferr_q,  ferr_d;
   logic                busy_q,  busy_d;

   // --------------------------------------------------------------------------
   // State and output registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         d_q     <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         d_q     <= d_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state and next-output logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      d_d     = d_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;

      // Every transition below is gated by en, so a cycle without the strobe
      // leaves state, counter and shift register exactly as they were.
      case (state_q)
         IDLE: begin
            if (en && !rx) begin
               state_d = DATA;
               cnt_d   = '0;
            end
         end

         DATA: begin
            if (en) begin
               shreg_d[cnt_q] = rx;
               if (cnt_q == LAST_BIT) begin
                  // Park the counter at 0 instead of letting it run past 4.
                  state_d = STOP;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         STOP: begin
            if (en) begin
               // A low stop sample is consumed here as the stop bit. It does
               // not also count as the start of the next frame.
               state_d = IDLE;
               if (rx) begin
                  d_d     = shreg_q;
                  valid_d = 1'b1;
               end else begin
                  ferr_d  = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // busy is registered from the next state, so it rises on the edge that
      // enters DATA and falls on the edge that returns to IDLE.
      busy_d = (state_d != IDLE);
   end

   assign D     = d_q;
   assign valid = valid_q;
   assign ferr  = ferr_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_serial_rx_5b.sv
module tb_serial_rx_5b;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       rx;
   logic [4:0] D;
   logic       valid;
   logic       ferr;
   logic       busy;

   serial_rx_5b dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .rx    (rx),
      .D     (D),
      .valid (valid),
      .ferr  (ferr),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   int nchecks = 0;
   int nerrors = 0;

   // Reference model: a frame is just the list of line samples taken since
   // a start bit was seen. Seven samples make a complete frame.
   bit         frame_q[$];
   logic [4:0] exp_D;
   logic       exp_valid;
   logic       exp_ferr;
   logic       exp_busy;

   // Per-scenario observation tallies.
   int mism, mism_tick;
   int vpulse, fpulse, both, bcnt;
   int tick_no, last_strobe, valid_lat;

   task automatic model_clear();
      frame_q.delete();
      exp_D     = 5'b0;
      exp_valid = 1'b0;
      exp_ferr  = 1'b0;
      exp_busy  = 1'b0;
   endtask

   task automatic model_step(input logic e, input logic r);
      exp_valid = 1'b0;
      exp_ferr  = 1'b0;
      if (e) begin
         if (frame_q.size() == 0) begin
            if (!r) frame_q.push_back(1'b0);
         end else begin
            frame_q.push_back(r);
            if (frame_q.size() == 7) begin
               if (r) begin
                  for (int i = 0; i < 5; i++) exp_D[i] = frame_q[i+1];
                  exp_valid = 1'b1;
               end else begin
                  exp_ferr = 1'b1;
               end
               frame_q.delete();
            end
         end
      end
      exp_busy = (frame_q.size() != 0);
   endtask

   task automatic clr_stats();
      mism = 0; mism_tick = -1;
      vpulse = 0; fpulse = 0; both = 0; bcnt = 0;
      valid_lat = -1;
   endtask

   // One clock: drive at the falling edge, sample 1 ns after the rising edge.
   task automatic tick(input logic e, input logic r);
      @(negedge clk);
      en = e;
      rx = r;
      @(posedge clk);
      if (reset) model_clear();
      else       model_step(e, r);
      #1;
      tick_no++;
      if (e) last_strobe = tick_no;
      if (D !== exp_D || valid !== exp_valid || ferr !== exp_ferr || busy !== exp_busy) begin
         if (mism == 0) mism_tick = tick_no;
         mism++;
      end
      if (valid === 1'b1) begin
         vpulse++;
         valid_lat = tick_no - last_strobe;
      end
      if (ferr === 1'b1) fpulse++;
      if (busy === 1'b1) bcnt++;
      if (valid === 1'b1 && ferr === 1'b1) both++;
   endtask

   // en every 4th clock with rx held for the whole bit period.
   task automatic send_bit(input logic b);
      tick(1'b0, b);
      tick(1'b0, b);
      tick(1'b0, b);
      tick(1'b1, b);
   endtask

   task automatic send_frame(input logic [4:0] d, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(d[i]);
      send_bit(stop);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      en    = 1'b0;
      rx    = 1'b1;
      model_clear();
      clr_stats();
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      nchecks++; if (D !== 5'b0) begin nerrors++; $display("FAIL reset_D: got %b expected 00000", D); end
      nchecks++; if (valid !== 1'b0) begin nerrors++; $display("FAIL reset_valid: got %b expected 0", valid); end
      nchecks++; if (ferr !== 1'b0) begin nerrors++; $display("FAIL reset_ferr: got %b expected 0", ferr); end
      nchecks++; if (busy !== 1'b0) begin nerrors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      @(negedge clk);
      reset = 1'b0;
      tick(1'b0, 1'b1);
   endtask

   task automatic test_basic_frame();
      clr_stats();
      send_frame(5'b01101, 1'b1);
      nchecks++; if (vpulse !== 1) begin nerrors++; $display("FAIL basic_valid_pulses: got %0d expected 1", vpulse); end
      nchecks++; if (D !== 5'b01101) begin nerrors++; $display("FAIL basic_D: got %b expected 01101", D); end
      nchecks++; if (fpulse !== 0) begin nerrors++; $display("FAIL basic_ferr: got %0d pulses expected 0", fpulse); end
      nchecks++; if (bcnt !== 24) begin nerrors++; $display("FAIL basic_busy_cycles: got %0d expected 24", bcnt); end
      nchecks++; if (valid_lat !== 0) begin nerrors++; $display("FAIL basic_latency: got %0d clk after strobe edge expected 0", valid_lat); end
      tick(1'b0, 1'b1);
      nchecks++; if (valid !== 1'b0) begin nerrors++; $display("FAIL basic_valid_width: got %b expected 0", valid); end
      nchecks++; if (mism !== 0) begin nerrors++; $display("FAIL basic_model: got %0d mismatches (first tick %0d) expected 0", mism, mism_tick); end
   endtask

   task automatic test_frame_error();
      clr_stats();
      send_frame(5'b10011, 1'b0);
      nchecks++; if (ferr !== 1'b1) begin nerrors++; $display("FAIL ferr_pulse: got %b expected 1", ferr); end
      nchecks++; if (busy !== 1'b0) begin nerrors++; $display("FAIL ferr_idle: busy got %b expected 0", busy); end
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      nchecks++; if (fpulse !== 1) begin nerrors++; $display("FAIL ferr_count: got %0d expected 1", fpulse); end
      nchecks++; if (vpulse !== 0) begin nerrors++; $display("FAIL ferr_valid: got %0d pulses expected 0", vpulse); end
      nchecks++; if (D !== 5'b01101) begin nerrors++; $display("FAIL ferr_D_hold: got %b expected 01101", D); end
      nchecks++; if (bcnt !== 24) begin nerrors++; $display("FAIL ferr_busy_cycles: got %0d expected 24", bcnt); end
      nchecks++; if (mism !== 0) begin nerrors++; $display("FAIL ferr_model: got %0d mismatches (first tick %0d) expected 0", mism, mism_tick); end
   endtask

   task automatic test_back_to_back();
      clr_stats();
      send_frame(5'b11111, 1'b1);
      nchecks++; if (D !== 5'b11111) begin nerrors++; $display("FAIL b2b_D1: got %b expected 11111", D); end
      send_frame(5'b00000, 1'b1);
      nchecks++; if (D !== 5'b00000) begin nerrors++; $display("FAIL b2b_D2: got %b expected 00000", D); end
      nchecks++; if (vpulse !== 2) begin nerrors++; $display("FAIL b2b_valid_pulses: got %0d expected 2", vpulse); end
      nchecks++; if (mism !== 0) begin nerrors++; $display("FAIL b2b_model: got %0d mismatches (first tick %0d) expected 0", mism, mism_tick); end
   endtask

   task automatic test_en_low_hold();
      logic [4:0] d;
      d = 5'($urandom);
      clr_stats();
      repeat (20) tick(1'b0, 1'b0);
      nchecks++; if (bcnt !== 0) begin nerrors++; $display("FAIL hold_busy_before: got %0d busy cycles expected 0", bcnt); end
      tick(1'b1, 1'b0);
      nchecks++; if (busy !== 1'b1) begin nerrors++; $display("FAIL hold_start: busy got %b expected 1", busy); end
      for (int i = 0; i < 5; i++) send_bit(d[i]);
      send_bit(1'b1);
      nchecks++; if (vpulse !== 1) begin nerrors++; $display("FAIL hold_valid_pulses: got %0d expected 1", vpulse); end
      nchecks++; if (D !== d) begin nerrors++; $display("FAIL hold_D: got %b expected %b", D, d); end
      nchecks++; if (mism !== 0) begin nerrors++; $display("FAIL hold_model: got %0d mismatches (first tick %0d) expected 0", mism, mism_tick); end
   endtask

   task automatic test_reset_midframe();
      logic [4:0] d;
      d = 5'($urandom) | 5'b00001;
      clr_stats();
      send_frame(d, 1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      nchecks++; if (busy !== 1'b1) begin nerrors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
      reset = 1'b1;
      model_clear();
      #1;
      nchecks++; if (D !== 5'b0) begin nerrors++; $display("FAIL mid_async_D: got %b expected 00000", D); end
      nchecks++; if (busy !== 1'b0) begin nerrors++; $display("FAIL mid_async_busy: got %b expected 0", busy); end
      nchecks++; if (valid !== 1'b0 || ferr !== 1'b0) begin nerrors++; $display("FAIL mid_async_pulses: got valid=%b ferr=%b expected 0 0", valid, ferr); end
      #2;
      reset = 1'b0;
      clr_stats();
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      send_frame(5'b00001, 1'b1);
      nchecks++; if (vpulse !== 1 || fpulse !== 0) begin nerrors++; $display("FAIL mid_after_pulses: got valid=%0d ferr=%0d expected 1 0", vpulse, fpulse); end
      nchecks++; if (D !== 5'b00001) begin nerrors++; $display("FAIL mid_after_D: got %b expected 00001", D); end
      nchecks++; if (mism !== 0) begin nerrors++; $display("FAIL mid_model: got %0d mismatches (first tick %0d) expected 0", mism, mism_tick); end
   endtask

   task automatic test_idle_line();
      clr_stats();
      repeat (50) send_bit(1'b1);
      nchecks++; if (bcnt !== 0) begin nerrors++; $display("FAIL idle_busy: got %0d busy cycles expected 0", bcnt); end
      nchecks++; if (vpulse !== 0 || fpulse !== 0) begin nerrors++; $display("FAIL idle_pulses: got valid=%0d ferr=%0d expected 0 0", vpulse, fpulse); end
   endtask

   // Random strobe spacing, noise on rx between strobes, random data,
   // occasional bad stop bits and random idle gaps.
   task automatic rand_bit(input logic b);
      repeat ($urandom_range(0, 3)) tick(1'b0, 1'($urandom));
      tick(1'b1, b);
   endtask

   task automatic test_random();
      int         exp_v, exp_f;
      logic [4:0] last_good, d;
      logic       stop;
      exp_v = 0;
      exp_f = 0;
      last_good = D;
      clr_stats();
      for (int f = 0; f < 40; f++) begin
         d    = 5'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         repeat ($urandom_range(0, 2)) rand_bit(1'b1);
         rand_bit(1'b0);
         for (int i = 0; i < 5; i++) rand_bit(d[i]);
         rand_bit(stop);
         if (stop) begin exp_v++; last_good = d; end
         else      exp_f++;
      end
      tick(1'b0, 1'b1);
      nchecks++; if (vpulse !== exp_v) begin nerrors++; $display("FAIL rand_valid_count: got %0d expected %0d", vpulse, exp_v); end
      nchecks++; if (fpulse !== exp_f) begin nerrors++; $display("FAIL rand_ferr_count: got %0d expected %0d", fpulse, exp_f); end
      nchecks++; if (both !== 0) begin nerrors++; $display("FAIL rand_both_high: got %0d cycles expected 0", both); end
      nchecks++; if (D !== last_good) begin nerrors++; $display("FAIL rand_last_D: got %b expected %b", D, last_good); end
      nchecks++; if (mism !== 0) begin nerrors++; $display("FAIL rand_model: got %0d mismatches (first tick %0d) expected 0", mism, mism_tick); end
   endtask

   initial begin
      tick_no     = 0;
      last_strobe = 0;
      test_reset();
      test_basic_frame();
      test_frame_error();
      test_back_to_back();
      test_en_low_hold();
      test_reset_midframe();
      test_idle_line();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule

// File: doc/serial_rx_5b.md
SERIAL_RX_5B -- requirements
Module: serial_rx_5b

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge system clock; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high; forces the reset state immediately, independent of clk.
REQ-004 en  input  1  bit-period strobe, synchronous to clk; rx is sampled only in cycles where en=1.
REQ-005 rx  input  1  serial line, synchronous to clk; idles high.
REQ-006 D  output  5  last correctly framed data word; D[0] is the first data bit received.
REQ-007 valid  output  1  one-cycle pulse: D holds a newly received word.
REQ-008 ferr  output  1  one-cycle pulse: stop bit sampled low, frame discarded.
REQ-009 busy  output  1  high while a frame is in progress.

Function
REQ-010 Frame format SHALL be: start bit (0), data bits D0..D4 (LSB first), stop bit (1), one bit per en strobe, 7 bit periods in total.
REQ-011 FSM states SHALL be IDLE, DATA, STOP.
REQ-012 IDLE: on en=1 with rx=0 -> DATA with bit counter=0; on en=1 with rx=1, or en=0 -> stay in IDLE.
REQ-013 DATA: on en=1, store rx into shift register bit [counter] and increment counter; after the 5th data sample (counter was 4) -> STOP.
REQ-014 STOP: on en=1 with rx=1 -> load D from the shift register, pulse valid, go to IDLE.
REQ-015 STOP: on en=1 with rx=0 -> leave D unchanged, pulse ferr, go to IDLE; that low sample SHALL NOT count as a start bit.
REQ-016 In any state, cycles with en=0 SHALL hold state, counter and shift register unchanged (no timeout).
REQ-017 Bit counter SHALL be 3 bits and range 0..4 only; it SHALL NOT wrap within a frame.
REQ-018 valid and ferr SHALL be registered, asserted in the clock cycle after the en cycle that sampled the stop bit, high for exactly one cycle, and never both high at once.
REQ-019 D SHALL update in the same edge that raises valid and SHALL hold its value until the next valid frame.
REQ-020 busy SHALL be registered: 1 from the edge entering DATA until the edge returning to IDLE, otherwise 0.
REQ-021 A start bit on the en strobe immediately after the stop-bit strobe SHALL be accepted (back-to-back frames, no idle gap required).
REQ-022 Latency: valid rises 1 clk after the 7th en strobe of a frame.

Reset
REQ-023 While reset=1: state=IDLE, counter=0, shift register=0, D=5'b00000, valid=0, ferr=0, busy=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no valid or ferr pulse, and D SHALL become 0.
REQ-025 After reset deasserts, the first frame SHALL be recognised only from a new start bit sampled in IDLE.

Verification
REQ-026 en every 4th clk; rx frame 0,1,0,1,1,0,1 (D=5'b01101) -> one valid pulse 1 clk after the stop strobe, D=5'b01101, ferr=0, busy high for 6 strobe periods.
REQ-027 Frame with data 5'b10011 and stop=0 -> ferr pulses once, valid stays 0, D keeps the previous value 5'b01101, FSM returns to IDLE.
REQ-028 Two back-to-back frames 5'b11111 then 5'b00000 with no idle bit -> two valid pulses, D=5'b11111 then 5'b00000.
REQ-029 rx held low with en=0 for 20 clk, then one en strobe -> exactly one start accepted; busy=0 until that strobe.
REQ-030 reset pulsed after the 3rd data strobe -> all outputs 0 immediately (asynchronous); a following full frame 5'b00001 is received correctly.
REQ-031 rx idle high with en strobing for 50 strobes -> busy, valid, ferr remain 0.
